// File: rtl/bank_fifo_multi.sv
// bank_fifo_multi: multi-bank FIFO; the writer fills one bank at a time and the reader drains whole committed banks in order.
module bank_fifo_multi #(
  parameter int W = 16,
  parameter int BANK_DEPTH = 256,
  parameter int BANK_COUNT = 4,
  localparam int AW = $clog2(BANK_DEPTH),
  localparam int BW = $clog2(BANK_COUNT),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          w_trigger,
  input  logic [W-1:0]  w_data,
  output logic          w_done,
  output logic          w_ready,
  input  logic          w_flush,
  input  logic          r_trigger,
  output logic [W-1:0]  r_data,
  output logic          r_done,
  output logic          r_last,
  output logic          r_ready,
  output logic [LW-1:0] r_len
);
  logic [W-1:0]          mem [BANK_COUNT*BANK_DEPTH];
  logic [BANK_COUNT-1:0] committed;
  logic [LW-1:0]         len [BANK_COUNT];
  logic [BW-1:0]         w_bank, r_bank;
  logic [AW-1:0]         w_idx, r_idx;
  logic                  w_commit, r_acc, r_end;
  logic [LW-1:0]         w_len;
  assign w_ready  = !committed[w_bank];
  assign w_done   = w_trigger && w_ready;
  // a flush with nothing written and no write this cycle would commit an empty bank
  assign w_commit = w_ready && (w_done ? (&w_idx || w_flush) : (w_flush && w_idx != '0));
  assign w_len    = LW'(w_idx) + (w_done ? LW'(1) : LW'(0));
  assign r_ready  = committed[r_bank];
  assign r_len    = len[r_bank];
  assign r_acc    = r_trigger && r_ready;
  assign r_end    = LW'(r_idx) == r_len - LW'(1);
  always_ff @(posedge clk)
    if (w_done) mem[{w_bank, w_idx}] <= w_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      committed <= '0;
      for (int i = 0; i < BANK_COUNT; i++) len[i] <= '0;
      w_bank <= '0;
      w_idx <= '0;
      r_bank <= '0;
      r_idx <= '0;
      r_data <= '0;
      r_done <= 1'b0;
      r_last <= 1'b0;
    end else begin
      r_done <= r_acc;
      r_last <= r_acc && r_end;
      if (w_commit) begin
        committed[w_bank] <= 1'b1;
        len[w_bank] <= w_len;
        w_bank <= w_bank + BW'(1);
        w_idx <= '0;
      end else if (w_done) w_idx <= w_idx + AW'(1);
      if (r_acc) begin
        r_data <= mem[{r_bank, r_idx}];
        if (r_end) begin
          committed[r_bank] <= 1'b0;
          r_bank <= r_bank + BW'(1);
          r_idx <= '0;
        end else r_idx <= r_idx + AW'(1);
      end
    end
endmodule

// File: tb/tb_bank_fifo_multi.sv
// tb_bank_fifo_multi: directed and random checks of bank_fifo_multi against a queue-based bank model.
module tb_bank_fifo_multi;
  localparam int W = 16;
  localparam int DEPTH = 256;
  localparam int BC = 4;
  localparam int LW = $clog2(DEPTH) + 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic w_trigger = 1'b0, w_flush = 1'b0, r_trigger = 1'b0;
  logic [W-1:0] w_data = '0;
  logic w_done, w_ready, r_done, r_last, r_ready;
  logic [W-1:0] r_data;
  logic [LW-1:0] r_len;
  int errors = 0;
  int checks = 0;
  logic [W-1:0] part[$];
  logic [W-1:0] pend[$];
  int len_q[$];
  int rd_pos = 0;
  bit exp_rdone = 0, exp_rlast = 0;
  logic [W-1:0] exp_rdata = '0;

  bank_fifo_multi #(.W(W), .BANK_DEPTH(DEPTH), .BANK_COUNT(BC)) dut (
    .clk(clk), .rst_n(rst_n), .w_trigger(w_trigger), .w_data(w_data), .w_done(w_done),
    .w_ready(w_ready), .w_flush(w_flush), .r_trigger(r_trigger), .r_data(r_data),
    .r_done(r_done), .r_last(r_last), .r_ready(r_ready), .r_len(r_len)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  function automatic void model_clear();
    part.delete();
    pend.delete();
    len_q.delete();
    rd_pos = 0;
    exp_rdone = 0;
    exp_rlast = 0;
  endfunction

  function automatic void reset_checks();
    chk("rst_w_ready", 32'(w_ready), 32'd1);
    chk("rst_w_done", 32'(w_done), 32'd0);
    chk("rst_r_ready", 32'(r_ready), 32'd0);
    chk("rst_r_done", 32'(r_done), 32'd0);
    chk("rst_r_last", 32'(r_last), 32'd0);
    chk("rst_r_data", 32'(r_data), 32'd0);
    chk("rst_r_len", 32'(r_len), 32'd0);
  endfunction

  // One clock: drive at the falling edge, check, then advance the model as the rising edge will.
  task automatic cycle(input bit wt, input logic [W-1:0] wd, input bit wf, input bit rt);
    bit wr, rr, racc;
    @(negedge clk);
    w_trigger = wt; w_data = wd; w_flush = wf; r_trigger = rt;
    #1;
    wr = len_q.size() < BC;
    rr = len_q.size() > 0;
    chk("w_ready", 32'(w_ready), 32'(wr));
    chk("r_ready", 32'(r_ready), 32'(rr));
    chk("w_done", 32'(w_done), 32'(wt && wr));
    if (rr) chk("r_len", 32'(r_len), 32'(len_q[0]));
    chk("r_done", 32'(r_done), 32'(exp_rdone));
    if (exp_rdone) begin
      chk("r_data", 32'(r_data), 32'(exp_rdata));
      chk("r_last", 32'(r_last), 32'(exp_rlast));
    end
    racc = rt && rr;
    exp_rdone = racc;
    if (racc) begin
      exp_rdata = pend.pop_front();
      exp_rlast = (rd_pos == len_q[0] - 1);
      rd_pos++;
      if (exp_rlast) begin
        void'(len_q.pop_front());
        rd_pos = 0;
      end
    end
    if (wt && wr) part.push_back(wd);
    if (wr && part.size() > 0 && (part.size() == DEPTH || wf)) begin
      foreach (part[i]) pend.push_back(part[i]);
      len_q.push_back(part.size());
      part.delete();
    end
    @(posedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((len_q.size() > 0 || part.size() > 0 || exp_rdone) && n < 5000) begin
      cycle(1'b0, '0, 1'b1, 1'b1);
      n++;
    end
    chk("drain_bound", 32'(n < 5000), 32'd1);
  endtask

  initial begin
    #3;
    reset_checks();
    @(negedge clk);
    rst_n = 1'b1;
    // fill two banks then drain them
    for (int i = 0; i < 2 * DEPTH; i++) cycle(1'b1, W'(i), 1'b0, 1'b0);
    drain();
    // partial flush, then a flush with nothing pending
    for (int i = 0; i < 3; i++) cycle(1'b1, W'(16'hA0 + i), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    // flush together with a write
    cycle(1'b1, 16'hB0, 1'b0, 1'b0);
    cycle(1'b1, 16'hB1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    // full stall, release one bank, resume
    for (int i = 0; i < BC * DEPTH; i++) cycle(1'b1, W'(16'h1000 + i), 1'b0, 1'b0);
    cycle(1'b1, 16'hDEAD, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 16'hBEEF, 1'b0, 1'b0);
    drain();
    // random concurrent streaming
    begin
      int nw = 0, n = 0;
      while ((nw < 10000 || len_q.size() > 0 || part.size() > 0 || exp_rdone) && n < 60000) begin
        bit wt;
        wt = nw < 10000 && $urandom_range(1) == 1;
        if (wt && len_q.size() < BC) nw++;
        cycle(wt, W'($urandom), nw >= 10000, $urandom_range(1) == 1);
        n++;
      end
      chk("stream_bound", 32'(n < 60000), 32'd1);
    end
    // reset mid-stream
    for (int i = 0; i < 300; i++) cycle(1'b1, W'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    w_trigger = 1'b0; w_flush = 1'b0; r_trigger = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks();
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, 16'h5A5A, 1'b1, 1'b0);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
